// File: rtl/data_mem_rmw.sv
// Sub-word load/store adapter onto a full-word memory port with one-cycle read
// latency; partial stores are done as read-merge-write, full-width stores write directly.
module data_mem_rmw #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [1:0] FULL_SIZE = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;

    typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic req_misaligned, req_bad_size, req_err;

    always_comb begin
        case (req_size_i)
            2'd1:    req_misaligned = req_addr_i[0];
            2'd2:    req_misaligned = |req_addr_i[1:0];
            2'd3:    req_misaligned = |req_addr_i[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    assign req_bad_size = (req_size_i == 2'd3) && (DATA_WIDTH != 64);
    assign req_err      = req_misaligned || req_bad_size;

    // Lane selection for the captured access: size_mask is right-aligned,
    // lane_mask is placed at the byte offset within the memory word.
    logic [OFF_W-1:0]      off;
    logic [NB-1:0]         size_mask, lane_mask;
    logic [DATA_WIDTH-1:0] keep_bits, wd_shift, rd_shift, merged, load_ext;
    logic                  sign_bit;

    assign off = addr_q[OFF_W-1:0];

    always_comb begin
        case (size_q)
            2'd0:    size_mask = NB'(1);
            2'd1:    size_mask = NB'(3);
            2'd2:    size_mask = NB'(15);
            default: size_mask = '1;
        endcase
    end

    assign lane_mask = size_mask << off;
    assign wd_shift  = wdata_q << {off, 3'b000};
    assign rd_shift  = mem_rdata_i >> {off, 3'b000};

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign merged[gi*8 +: 8]    = lane_mask[gi] ? wd_shift[gi*8 +: 8] : mem_rdata_i[gi*8 +: 8];
            assign keep_bits[gi*8 +: 8] = {8{size_mask[gi]}};
        end
    endgenerate

    always_comb begin
        case (size_q)
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[DATA_WIDTH-1];
        endcase
    end

    // A full-width load has keep_bits all ones, so the fill term vanishes.
    assign load_ext = (rd_shift & keep_bits) | ((sign_bit && !uns_q) ? ~keep_bits : '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (req_we_i && (req_size_i == FULL_SIZE))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                mem_re_o = 1'b1;
                state_d  = MRG;
            end
            MRG: begin
                if (we_q) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = merged;
                end else begin
                    rdata_d = load_ext;
                end
                state_d = RESP;
            end
            WR: begin
                mem_we_o    = 1'b1;
                mem_wdata_o = wdata_q;
                state_d     = RESP;
            end
            RESP: begin
                if (resp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign mem_addr_o   = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};

endmodule

// File: tb/tb_data_mem_rmw.sv
// Scoreboard bench for data_mem_rmw: 32-bit instance for the bulk of the
// scenarios, 64-bit instance for dword and upper-lane merges.
module tb_data_mem_rmw;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, req_uns, resp_valid, resp_ready, resp_err, mem_re, mem_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        v_valid, v_ready, v_we, v_uns, v_resp_valid, v_resp_ready, v_err, v_re, v_mwe;
    logic [1:0]  v_size;
    logic [31:0] v_addr, v_maddr;
    logic [63:0] v_wdata, v_rdata, v_mwdata, v_mrdata;

    data_mem_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err), .mem_addr_o(mem_addr),
        .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    data_mem_rmw #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid_i(v_valid), .req_ready_o(v_ready), .req_we_i(v_we),
        .req_addr_i(v_addr), .req_size_i(v_size), .req_unsigned_i(v_uns),
        .req_wdata_i(v_wdata), .resp_valid_o(v_resp_valid), .resp_ready_i(v_resp_ready),
        .resp_rdata_o(v_rdata), .resp_err_o(v_err), .mem_addr_o(v_maddr),
        .mem_re_o(v_re), .mem_we_o(v_mwe), .mem_wdata_o(v_mwdata), .mem_rdata_i(v_mrdata)
    );

    // Memory models: read data registered one cycle after the strobe.
    logic [31:0] mem32 [0:15];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem32[mem_addr[5:2]];
        if (mem_we) mem32[mem_addr[5:2]] <= mem_wdata;
        if (pre_en) mem32[pre_idx] <= pre_data;
    end

    logic [63:0] mem64 [0:3];
    always @(posedge clk) begin
        if (v_re)  v_mrdata <= mem64[v_maddr[4:3]];
        if (v_mwe) mem64[v_maddr[4:3]] <= v_mwdata;
    end

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] mb [0:15];

    task automatic push_exp(input logic [63:0] rd, input logic er);
        exp_t x;
        x.rdata = rd;
        x.err   = er;
        sb.push_back(x);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] wd, input int hold,
                          output int lat, output int re_cnt, output int we_cnt, output int we_cyc,
                          output logic [31:0] we_data, output logic [31:0] re_addr,
                          output logic [31:0] rdata, output logic err, output logic stable);
        lat = -1; re_cnt = 0; we_cnt = 0; we_cyc = -1; we_data = '0; re_addr = '0; stable = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_re) begin re_cnt++; re_addr = mem_addr; end
            if (mem_we) begin we_cnt++; we_cyc = c; we_data = mem_wdata; end
            if (resp_valid) lat = c;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!resp_valid || req_ready || resp_rdata !== rdata || resp_err !== err) stable = 1'b0;
            end
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
        $display("txn32 we=%0d addr=%h size=%0d uns=%0d wd=%h -> rdata=%h err=%0d lat=%0d",
                 we, addr, size, uns, wd, rdata, err, lat);
    endtask

    task automatic do_req64(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                            input logic [63:0] wd,
                            output int lat, output int re_cnt, output logic [63:0] we_data,
                            output logic [63:0] rdata, output logic err);
        lat = -1; re_cnt = 0; we_data = '0;
        @(negedge clk);
        v_valid = 1'b1; v_we = we; v_addr = addr; v_size = size; v_uns = uns; v_wdata = wd;
        @(posedge clk);
        #1 v_valid = 1'b0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (v_re) re_cnt++;
            if (v_mwe) we_data = v_mwdata;
            if (v_resp_valid) lat = c;
        end
        rdata = v_rdata;
        err   = v_err;
        if (lat > 0) begin
            v_resp_ready = 1'b1;
            @(posedge clk);
            #1 v_resp_ready = 1'b0;
        end
        $display("txn64 we=%0d addr=%h size=%0d uns=%0d wd=%h -> rdata=%h err=%0d lat=%0d",
                 we, addr, size, uns, wd, rdata, err, lat);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_vec++; if (resp_err !== 1'b0)    begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_vec++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_vec++; if ({mem_re, mem_we} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {mem_re, mem_we}); end
        n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_store_byte;
        int lat, rc, wc, wcyc; logic [31:0] wdat, raddr, rd; logic er, st; exp_t e;
        preload(4'd0, 32'h11223344);
        push_exp(64'h0, 1'b0);
        do_req(1'b1, 32'h2, 2'd0, 1'b0, 32'h000000AA, 0, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
        e = sb.pop_front();
        n_vec++; if (rd !== e.rdata[31:0] || er !== e.err) begin n_bad++; $display("FAIL sb_store_byte: got %h/%b want %h/%b", rd, er, e.rdata[31:0], e.err); end
        n_vec++; if (rc !== 1 || raddr !== 32'h0) begin n_bad++; $display("FAIL store_byte_read: got cnt=%0d addr=%h want 1/0", rc, raddr); end
        n_vec++; if (wc !== 1 || wcyc !== 2) begin n_bad++; $display("FAIL store_byte_we: got cnt=%0d cyc=%0d want 1/2", wc, wcyc); end
        n_vec++; if (wdat !== 32'h11AA3344) begin n_bad++; $display("FAIL store_byte_merge: got %h want 11aa3344", wdat); end
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL store_byte_lat: got %0d want 3", lat); end
        n_vec++; if (mem32[0] !== 32'h11AA3344) begin n_bad++; $display("FAIL store_byte_mem: got %h want 11aa3344", mem32[0]); end
    endtask

    task automatic test_load;
        logic [31:0] t_addr [6] = '{32'h2, 32'h1, 32'h0, 32'h1, 32'h2, 32'h0};
        logic [1:0]  t_size [6] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        logic        t_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_exp  [6] = '{32'hFFFF8000, 32'h000000FF, 32'h0000007F, 32'hFFFFFFFF, 32'h00008000, 32'h8000FF7F};
        int lat, rc, wc, wcyc; logic [31:0] wdat, raddr, rd; logic er, st; exp_t e;
        preload(4'd0, 32'h8000FF7F);
        for (int i = 0; i < 6; i++) begin
            push_exp({32'h0, t_exp[i]}, 1'b0);
            do_req(1'b0, t_addr[i], t_size[i], t_uns[i], 32'h0, 0, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
            e = sb.pop_front();
            n_vec++; if (rd !== e.rdata[31:0] || er !== e.err) begin n_bad++; $display("FAIL sb_load%0d: got %h/%b want %h/%b", i, rd, er, e.rdata[31:0], e.err); end
            n_vec++; if (lat !== 3 || rc !== 1 || wc !== 0) begin n_bad++; $display("FAIL load%0d_timing: got lat=%0d re=%0d we=%0d want 3/1/0", i, lat, rc, wc); end
        end
    endtask

    task automatic test_full_store;
        int lat, rc, wc, wcyc; logic [31:0] wdat, raddr, rd; logic er, st; exp_t e;
        push_exp(64'h0, 1'b0);
        do_req(1'b1, 32'h4, 2'd2, 1'b0, 32'hDEADBEEF, 0, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
        e = sb.pop_front();
        n_vec++; if (rd !== e.rdata[31:0] || er !== e.err) begin n_bad++; $display("FAIL sb_full_store: got %h/%b want %h/%b", rd, er, e.rdata[31:0], e.err); end
        n_vec++; if (rc !== 0) begin n_bad++; $display("FAIL full_store_no_read: got %0d want 0", rc); end
        n_vec++; if (wc !== 1 || wcyc !== 1 || wdat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_store_we: got cnt=%0d cyc=%0d data=%h want 1/1/deadbeef", wc, wcyc, wdat); end
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL full_store_lat: got %0d want 2", lat); end
        n_vec++; if (mem32[1] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_store_mem: got %h want deadbeef", mem32[1]); end
    endtask

    task automatic test_errors;
        logic        t_we   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_addr [4] = '{32'h3, 32'h0, 32'h2, 32'h1};
        logic [1:0]  t_size [4] = '{2'd1, 2'd3, 2'd2, 2'd2};
        int lat, rc, wc, wcyc; logic [31:0] wdat, raddr, rd; logic er, st; exp_t e;
        preload(4'd0, 32'h13572468);
        for (int i = 0; i < 4; i++) begin
            push_exp(64'h0, 1'b1);
            do_req(t_we[i], t_addr[i], t_size[i], 1'b0, 32'hFFFFFFFF, 0, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
            e = sb.pop_front();
            n_vec++; if (rd !== e.rdata[31:0] || er !== e.err) begin n_bad++; $display("FAIL sb_err%0d: got %h/%b want %h/%b", i, rd, er, e.rdata[31:0], e.err); end
            n_vec++; if (lat !== 1 || rc !== 0 || wc !== 0) begin n_bad++; $display("FAIL err%0d_timing: got lat=%0d re=%0d we=%0d want 1/0/0", i, lat, rc, wc); end
        end
        n_vec++; if (mem32[0] !== 32'h13572468) begin n_bad++; $display("FAIL err_mem_untouched: got %h want 13572468", mem32[0]); end
    endtask

    task automatic test_stall;
        int lat, rc, wc, wcyc; logic [31:0] wdat, raddr, rd; logic er, st; exp_t e;
        preload(4'd2, 32'h0BADCAFE);
        push_exp({32'h0, 32'h0BADCAFE}, 1'b0);
        do_req(1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 5, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
        e = sb.pop_front();
        n_vec++; if (rd !== e.rdata[31:0] || er !== e.err) begin n_bad++; $display("FAIL sb_stall: got %h/%b want %h/%b", rd, er, e.rdata[31:0], e.err); end
        n_vec++; if (st !== 1'b1) begin n_bad++; $display("FAIL stall_hold: got stable=%b want 1", st); end
    endtask

    task automatic test_reset_mid;
        int lat, rc, wc, wcyc; logic [31:0] wdat, raddr, rd; logic er, st; exp_t e;
        preload(4'd3, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hD; req_size = 2'd0; req_uns = 1'b0; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL mid_in_merge: got mem_we=%b want 1", mem_we); end
        rst = 1'b1;
        #1;
        n_vec++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_bad++; $display("FAIL mid_strobes: got re=%b we=%b want 0/0", mem_re, mem_we); end
        n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_handshake: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (mem32[3] !== 32'h55667788) begin n_bad++; $display("FAIL mid_mem_untouched: got %h want 55667788", mem32[3]); end
        push_exp({32'h0, 32'h00000077}, 1'b0);
        do_req(1'b0, 32'hD, 2'd0, 1'b1, 32'h0, 0, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
        e = sb.pop_front();
        n_vec++; if (rd !== e.rdata[31:0] || er !== e.err || lat !== 3) begin n_bad++; $display("FAIL sb_after_reset: got %h/%b lat=%0d want %h/%b lat=3", rd, er, lat, e.rdata[31:0], e.err); end
    endtask

    task automatic test_back_to_back;
        int lat, rc, wc, wcyc, nb, off, elat; logic [31:0] wdat, raddr, rd, a, wd, ev; logic er, st, we, uns; logic [1:0] sz; exp_t e;
        for (int b = 0; b < 16; b++) mb[b] = 8'($urandom());
        for (int w = 0; w < 4; w++) preload(4'(8 + w), {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]});
        for (int k = 0; k < 20; k++) begin
            sz  = 2'($urandom_range(2, 0));
            nb  = 1 << sz;
            off = int'($urandom_range(15, 0)) & ~(nb - 1);
            a   = 32'h20 + 32'(off);
            we  = 1'($urandom_range(1, 0));
            uns = 1'($urandom_range(1, 0));
            wd  = $urandom();
            ev  = '0;
            if (we) begin
                for (int b = 0; b < nb; b++) mb[off+b] = wd[8*b +: 8];
            end else begin
                for (int b = 0; b < nb; b++) ev[8*b +: 8] = mb[off+b];
                if (!uns && ev[8*nb-1]) for (int b = 8*nb; b < 32; b++) ev[b] = 1'b1;
            end
            elat = (we && sz == 2'd2) ? 2 : 3;
            push_exp({32'h0, ev}, 1'b0);
            do_req(we, a, sz, uns, wd, 0, lat, rc, wc, wcyc, wdat, raddr, rd, er, st);
            e = sb.pop_front();
            n_vec++; if (rd !== e.rdata[31:0] || er !== e.err || lat !== elat) begin n_bad++; $display("FAIL sb_b2b%0d: got %h/%b lat=%0d want %h/%b lat=%0d", k, rd, er, lat, e.rdata[31:0], e.err, elat); end
        end
        for (int w = 0; w < 4; w++) begin
            n_vec++; if (mem32[8+w] !== {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]}) begin n_bad++; $display("FAIL b2b_mem%0d: got %h want %h", w, mem32[8+w], {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]}); end
        end
    endtask

    task automatic test_wide64;
        logic        t_we   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_addr [6] = '{32'h8, 32'hC, 32'hC, 32'h8, 32'hA, 32'h4};
        logic [1:0]  t_size [6] = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd3};
        logic        t_uns  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [63:0] t_wd   [6] = '{64'h0123456789ABCDEF, 64'h00000000CAFEF00D, 64'h0, 64'h0, 64'h0, 64'h0};
        logic [63:0] t_exp  [6] = '{64'h0, 64'h0, 64'hFFFFFFFFCAFEF00D, 64'hCAFEF00D89ABCDEF, 64'h00000000000089AB, 64'h0};
        logic        t_err  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          t_lat  [6] = '{2, 3, 3, 3, 3, 1};
        logic [63:0] t_wdat [6] = '{64'h0123456789ABCDEF, 64'hCAFEF00D89ABCDEF, 64'h0, 64'h0, 64'h0, 64'h0};
        int lat, rc; logic [63:0] wdat, rd; logic er; exp_t e;
        for (int i = 0; i < 6; i++) begin
            push_exp(t_exp[i], t_err[i]);
            do_req64(t_we[i], t_addr[i], t_size[i], t_uns[i], t_wd[i], lat, rc, wdat, rd, er);
            e = sb.pop_front();
            n_vec++; if (rd !== e.rdata || er !== e.err) begin n_bad++; $display("FAIL sb_w64_%0d: got %h/%b want %h/%b", i, rd, er, e.rdata, e.err); end
            n_vec++; if (lat !== t_lat[i] || wdat !== t_wdat[i]) begin n_bad++; $display("FAIL w64_%0d_bus: got lat=%0d wdata=%h want %0d/%h", i, lat, wdat, t_lat[i], t_wdat[i]); end
        end
        n_vec++; if (mem64[1] !== 64'hCAFEF00D89ABCDEF) begin n_bad++; $display("FAIL w64_mem: got %h want cafef00d89abcdef", mem64[1]); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0; req_uns = 1'b0; req_wdata = '0; resp_ready = 1'b0;
        v_valid = 1'b0; v_we = 1'b0; v_addr = '0; v_size = 2'd0; v_uns = 1'b0; v_wdata = '0; v_resp_ready = 1'b0;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        repeat (2) @(posedge clk);
        test_reset;
        rst = 1'b0;
        test_store_byte;
        test_load;
        test_full_store;
        test_errors;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        test_wide64;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_rmw.md
DATA_MEM_RMW -- requirements
Module: data_mem_rmw

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the memory word width; legal values are 32 and 64.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 Port clk, input, 1, is the single clock; all state updates SHALL occur on its rising edge.
REQ-004 Port rst, input, 1, is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port req_valid_i, input, 1, indicates a request is presented.
REQ-006 Port req_ready_o, output, 1, indicates the block accepts a request this cycle.
REQ-007 Port req_we_i, input, 1, selects store (1) or load (0).
REQ-008 Port req_addr_i, input, ADDR_WIDTH, is the byte address.
REQ-009 Port req_size_i, input, 2, selects 00 byte, 01 half, 10 word, 11 dword; dword is legal only when DATA_WIDTH=64.
REQ-010 Port req_unsigned_i, input, 1, selects zero-extension (1) or sign-extension (0) for loads.
REQ-011 Port req_wdata_i, input, DATA_WIDTH, carries store data, right-aligned.
REQ-012 Port resp_valid_o, output, 1, indicates a response is held.
REQ-013 Port resp_ready_i, input, 1, indicates the consumer takes the response.
REQ-014 Port resp_rdata_o, output, DATA_WIDTH, carries load data, extended and right-aligned.
REQ-015 Port resp_err_o, output, 1, flags a misaligned or illegal-size access.
REQ-016 Port mem_addr_o, output, ADDR_WIDTH, carries the word-aligned address, with the low log2(DATA_WIDTH/8) bits zero.
REQ-017 Ports mem_re_o and mem_we_o, outputs, 1 each, are the memory read and write strobes.
REQ-018 Port mem_wdata_o, output, DATA_WIDTH, carries the full merged word.
REQ-019 Port mem_rdata_i, input, DATA_WIDTH, carries read data valid exactly one cycle after mem_re_o.

Function
REQ-020 The FSM SHALL have the states IDLE, RD, MRG, WR and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-021 On a request accepted in IDLE, the block SHALL register the address, size, unsigned flag, we and wdata.
REQ-022 An access SHALL be misaligned when the address is not a multiple of its size in bytes.
REQ-023 A misaligned or illegal-size request SHALL go IDLE->RESP with resp_err_o=1 and resp_rdata_o=0, and SHALL issue no memory strobe.
REQ-024 A full-width aligned store SHALL go IDLE->WR->RESP; in WR, mem_we_o=1 and mem_wdata_o equals the stored wdata.
REQ-025 All other legal requests SHALL go IDLE->RD->MRG; in RD, mem_re_o=1 for exactly one cycle.
REQ-026 In MRG for a store, the block SHALL replace the addressed byte lanes of mem_rdata_i with the low bytes of wdata, leave the other lanes unchanged, drive mem_we_o=1 for that one cycle, then go to RESP.
REQ-027 In MRG for a load, the block SHALL shift the addressed lanes to bit 0, extend them to DATA_WIDTH per req_unsigned_i, register the result into resp_rdata_o, then go to RESP; a full-width load needs no extension.
REQ-028 In RESP, resp_valid_o SHALL be 1 and resp_rdata_o/resp_err_o SHALL be held stable until resp_ready_i=1, then the FSM SHALL return to IDLE.
REQ-029 Stores SHALL return resp_rdata_o=0.
REQ-030 Latency from the acceptance edge to resp_valid_o SHALL be 1 cycle for an error, 2 cycles for a full-width store, and 3 cycles for all other requests; throughput is one request per FSM pass.
REQ-031 mem_re_o and mem_we_o SHALL never both be 1, and SHALL be 0 outside RD/MRG/WR.
REQ-032 While a request is outstanding, a new req_valid_i SHALL be ignored and must be held by the requester.

Reset
REQ-033 Asserting rst, including mid-operation, SHALL immediately force state IDLE and set req_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, mem_re_o=0, mem_we_o=0, mem_addr_o=0 and mem_wdata_o=0; a partial RMW SHALL be abandoned with no write.

Verification
REQ-034 A bench SHALL check: memory word 0x11223344, store byte 0xAA to addr 0x2 -> RD, then mem_we with mem_wdata_o=0x11AA3344, resp at cycle 3.
REQ-035 A bench SHALL check: memory word 0x8000FF7F, load half signed at 0x2 -> 0xFFFF8000; load byte unsigned at 0x1 -> 0x000000FF.
REQ-036 A bench SHALL check: store word 0xDEADBEEF to 0x4 -> no mem_re, mem_we in cycle 1 with 0xDEADBEEF, resp at cycle 2.
REQ-037 A bench SHALL check: load half at 0x3 -> no strobes, resp_err_o=1 at cycle 1; size 11 with DATA_WIDTH=32 -> resp_err_o=1.
REQ-038 A bench SHALL check: with resp_ready_i held at 0 for 5 cycles, resp_valid_o and the data stay stable and req_ready_o=0 throughout.
REQ-039 A bench SHALL check: rst asserted during MRG of a store -> mem_we_o drops immediately, memory is unchanged, req_ready_o=1, and the next request completes normally; at DATA_WIDTH=64, a dword store at 0x8 and a word store at 0xC merge into the upper lanes.
